// File: rtl/cache_ctrl_if.sv
// Processor-side and memory-side bus of the cache controller, plus its statistics counters.
// The slave modport is the controller; the master modport is the environment that drives it.
interface cache_ctrl_if #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 8,
   parameter int CNT_W  = 8
);
   logic              cpu_req;
   logic              cpu_rwb;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_ready;
   logic              busy;
   logic              mem_req;
   logic              mem_rwb;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;
   logic [CNT_W-1:0]  hit_cnt;
   logic [CNT_W-1:0]  miss_cnt;

   modport slave (
      input  cpu_req, cpu_rwb, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
      output cpu_rdata, cpu_ready, busy, mem_req, mem_rwb, mem_addr, mem_wdata,
             hit_cnt, miss_cnt
   );

   modport master (
      output cpu_req, cpu_rwb, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
      input  cpu_rdata, cpu_ready, busy, mem_req, mem_rwb, mem_addr, mem_wdata,
             hit_cnt, miss_cnt
   );
endinterface

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller with one word per line.
// Read hits complete in one cycle; read misses and all writes run a single memory transaction.
module cache_ctrl #(
   parameter int ADDR_W  = 6,
   parameter int DATA_W  = 8,
   parameter int INDEX_W = 3,
   parameter int CNT_W   = 8
) (
   input  logic        clk,
   input  logic        start,
   cache_ctrl_if.slave bus
);
   localparam int TAG_W = ADDR_W - INDEX_W;
   localparam int LINES = 1 << INDEX_W;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] RD_MISS = 2'd1;
   localparam logic [1:0] WR_THRU = 2'd2;

   logic [TAG_W-1:0]  tag_mem  [LINES];
   logic [DATA_W-1:0] data_mem [LINES];
   logic [LINES-1:0]  valid_reg;

   logic [1:0]        state_reg;
   logic              busy_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [DATA_W-1:0] wdata_reg;
   logic              mem_req_reg;
   logic              mem_rwb_reg;
   logic              cpu_ready_reg;
   logic [DATA_W-1:0] cpu_rdata_reg;
   logic [CNT_W-1:0]  hit_cnt_reg;
   logic [CNT_W-1:0]  miss_cnt_reg;

   logic [INDEX_W-1:0] cpu_idx;
   logic [TAG_W-1:0]   cpu_tag;
   logic [INDEX_W-1:0] lat_idx;
   logic [TAG_W-1:0]   lat_tag;
   logic               accept;
   logic               hit;
   logic               fill;
   logic               data_we;
   logic               tag_we;
   logic [INDEX_W-1:0] data_wa;
   logic [DATA_W-1:0]  data_wd;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

   assign cpu_idx = bus.cpu_addr[INDEX_W-1:0];
   assign cpu_tag = bus.cpu_addr[ADDR_W-1:INDEX_W];
   assign lat_idx = addr_reg[INDEX_W-1:0];
   assign lat_tag = addr_reg[ADDR_W-1:INDEX_W];
   assign accept  = (state_reg == IDLE) && bus.cpu_req;
   assign hit     = valid_reg[cpu_idx] && (tag_mem[cpu_idx] == cpu_tag);
   assign fill    = (state_reg == RD_MISS) && bus.mem_ack;

   // Array write port: write hits update at accept, read misses fill on ack.
   // Reset suppresses both so an aborted transaction leaves the arrays untouched.
   always_comb begin
      data_we = 1'b0;
      tag_we  = 1'b0;
      data_wa = cpu_idx;
      data_wd = bus.cpu_wdata;
      if (!start) begin
         if (accept && !bus.cpu_rwb && hit) begin
            data_we = 1'b1;
         end else if (fill) begin
            data_we = 1'b1;
            tag_we  = 1'b1;
            data_wa = lat_idx;
            data_wd = bus.mem_rdata;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (data_we) data_mem[data_wa] <= data_wd;
      if (tag_we)  tag_mem[lat_idx]  <= lat_tag;
   end

   always_ff @(posedge clk) begin
      if (start) begin
         state_reg     <= IDLE;
         busy_reg      <= 1'b0;
         valid_reg     <= '0;
         addr_reg      <= '0;
         wdata_reg     <= '0;
         mem_req_reg   <= 1'b0;
         mem_rwb_reg   <= 1'b0;
         cpu_ready_reg <= 1'b0;
         cpu_rdata_reg <= '0;
         hit_cnt_reg   <= '0;
         miss_cnt_reg  <= '0;
      end else begin
         cpu_ready_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (bus.cpu_req) begin
                  addr_reg    <= bus.cpu_addr;
                  wdata_reg   <= bus.cpu_wdata;
                  mem_rwb_reg <= bus.cpu_rwb;
                  if (hit) hit_cnt_reg  <= sat_inc(hit_cnt_reg);
                  else     miss_cnt_reg <= sat_inc(miss_cnt_reg);
                  if (bus.cpu_rwb && hit) begin
                     cpu_ready_reg <= 1'b1;
                     cpu_rdata_reg <= data_mem[cpu_idx];
                  end else begin
                     mem_req_reg <= 1'b1;
                     busy_reg    <= 1'b1;
                     state_reg   <= bus.cpu_rwb ? RD_MISS : WR_THRU;
                  end
               end
            end
            RD_MISS: begin
               if (bus.mem_ack) begin
                  valid_reg[lat_idx] <= 1'b1;
                  cpu_rdata_reg      <= bus.mem_rdata;
                  cpu_ready_reg      <= 1'b1;
                  mem_req_reg        <= 1'b0;
                  busy_reg           <= 1'b0;
                  state_reg          <= IDLE;
               end
            end
            WR_THRU: begin
               if (bus.mem_ack) begin
                  cpu_ready_reg <= 1'b1;
                  mem_req_reg   <= 1'b0;
                  busy_reg      <= 1'b0;
                  state_reg     <= IDLE;
               end
            end
            default: begin
               mem_req_reg <= 1'b0;
               busy_reg    <= 1'b0;
               state_reg   <= IDLE;
            end
         endcase
      end
   end

   assign bus.cpu_rdata = cpu_rdata_reg;
   assign bus.cpu_ready = cpu_ready_reg;
   assign bus.busy      = busy_reg;
   assign bus.mem_req   = mem_req_reg;
   assign bus.mem_rwb   = mem_rwb_reg;
   assign bus.mem_addr  = addr_reg;
   assign bus.mem_wdata = wdata_reg;
   assign bus.hit_cnt   = hit_cnt_reg;
   assign bus.miss_cnt  = miss_cnt_reg;
endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: inputs change and outputs are sampled on the falling edge,
// the bench itself plays main memory with a chosen ack delay and read data.
module tb_cache_ctrl;
   logic clk;
   logic start;
   int   vectors;
   int   miscompares;
   logic [7:0] exp_hit_cnt;
   logic [7:0] exp_miss_cnt;

   cache_ctrl_if #(.ADDR_W(6), .DATA_W(8), .CNT_W(8)) ifc ();

   cache_ctrl #(.ADDR_W(6), .DATA_W(8), .INDEX_W(3), .CNT_W(8)) dut (
      .clk   (clk),
      .start (start),
      .bus   (ifc.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_counters(input string tag);
      check({tag, " hit_cnt"}, 32'(ifc.hit_cnt), 32'(exp_hit_cnt));
      check({tag, " miss_cnt"}, 32'(ifc.miss_cnt), 32'(exp_miss_cnt));
   endtask

   task automatic do_reset();
      start = 1'b1;
      repeat (2) @(negedge clk);
      start = 1'b0;
      exp_hit_cnt  = 8'd0;
      exp_miss_cnt = 8'd0;
   endtask

   // One complete processor access. exp_hit is the hand-computed outcome; for memory
   // transactions the bench acks on the dly-th cycle of mem_req, returning mdata.
   task automatic access(input string tag, input bit rd, input logic [5:0] addr,
                         input logic [7:0] wdata, input bit exp_hit, input int dly,
                         input logic [7:0] mdata, input logic [7:0] exp_rdata);
      ifc.cpu_req   = 1'b1;
      ifc.cpu_rwb   = rd;
      ifc.cpu_addr  = addr;
      ifc.cpu_wdata = wdata;
      @(negedge clk);
      ifc.cpu_req = 1'b0;
      if (exp_hit) exp_hit_cnt  = (exp_hit_cnt  == 8'hFF) ? 8'hFF : exp_hit_cnt + 8'd1;
      else         exp_miss_cnt = (exp_miss_cnt == 8'hFF) ? 8'hFF : exp_miss_cnt + 8'd1;
      if (rd && exp_hit) begin
         check({tag, " hit ready"}, 32'(ifc.cpu_ready), 32'd1);
         check({tag, " hit rdata"}, 32'(ifc.cpu_rdata), 32'(exp_rdata));
         check({tag, " hit mem_req"}, 32'(ifc.mem_req), 32'd0);
         check({tag, " hit busy"}, 32'(ifc.busy), 32'd0);
      end else begin
         for (int k = 1; k <= dly; k++) begin
            if (k > 1) @(negedge clk);
            check($sformatf("%s mem_req c%0d", tag, k), 32'(ifc.mem_req), 32'd1);
            check($sformatf("%s ready low c%0d", tag, k), 32'(ifc.cpu_ready), 32'd0);
            check($sformatf("%s mem_addr c%0d", tag, k), 32'(ifc.mem_addr), 32'(addr));
            if (k == 1) begin
               check({tag, " mem_rwb"}, 32'(ifc.mem_rwb), 32'(rd));
               check({tag, " busy"}, 32'(ifc.busy), 32'd1);
               if (!rd) check({tag, " mem_wdata"}, 32'(ifc.mem_wdata), 32'(wdata));
            end
            if (k == dly) begin
               ifc.mem_ack   = 1'b1;
               ifc.mem_rdata = mdata;
            end
         end
         @(negedge clk);
         ifc.mem_ack   = 1'b0;
         ifc.mem_rdata = 8'hEE;
         check({tag, " done ready"}, 32'(ifc.cpu_ready), 32'd1);
         check({tag, " done mem_req"}, 32'(ifc.mem_req), 32'd0);
         check({tag, " done busy"}, 32'(ifc.busy), 32'd0);
         if (rd) check({tag, " done rdata"}, 32'(ifc.cpu_rdata), 32'(exp_rdata));
      end
      @(negedge clk);
      check({tag, " ready pulse"}, 32'(ifc.cpu_ready), 32'd0);
      check_counters(tag);
      $display("access %s %s addr=0x%02h hit=%0d rdata=0x%02h", tag, rd ? "RD" : "WR",
               addr, exp_hit, ifc.cpu_rdata);
   endtask

   initial begin
      vectors       = 0;
      miscompares   = 0;
      ifc.cpu_req   = 1'b0;
      ifc.cpu_rwb   = 1'b1;
      ifc.cpu_addr  = '0;
      ifc.cpu_wdata = '0;
      ifc.mem_ack   = 1'b0;
      ifc.mem_rdata = 8'hEE;

      // Reset state
      do_reset();
      check("rst busy", 32'(ifc.busy), 32'd0);
      check("rst cpu_ready", 32'(ifc.cpu_ready), 32'd0);
      check("rst mem_req", 32'(ifc.mem_req), 32'd0);
      check("rst cpu_rdata", 32'(ifc.cpu_rdata), 32'd0);
      check("rst mem_addr", 32'(ifc.mem_addr), 32'd0);
      check_counters("rst");

      // 1: cold miss with 3-cycle memory, then hit
      access("t1 miss", 1'b1, 6'h2A, 8'h00, 1'b0, 3, 8'h5C, 8'h5C);
      access("t1 hit", 1'b1, 6'h2A, 8'h00, 1'b1, 0, 8'h00, 8'h5C);

      // 2: conflict on index 2
      do_reset();
      access("t2 a", 1'b1, 6'h02, 8'h00, 1'b0, 1, 8'h11, 8'h11);
      access("t2 b", 1'b1, 6'h0A, 8'h00, 1'b0, 2, 8'h22, 8'h22);
      access("t2 a again", 1'b1, 6'h02, 8'h00, 1'b0, 1, 8'h33, 8'h33);
      check("t2 miss_cnt==3", 32'(ifc.miss_cnt), 32'd3);

      // 3: write-through hit, no-allocate write miss
      access("t3 fill", 1'b1, 6'h2A, 8'h00, 1'b0, 1, 8'h5C, 8'h5C);
      access("t3 wr hit", 1'b0, 6'h2A, 8'h77, 1'b1, 2, 8'h00, 8'h00);
      access("t3 rd hit", 1'b1, 6'h2A, 8'h00, 1'b1, 0, 8'h00, 8'h77);
      access("t3 wr miss", 1'b0, 6'h11, 8'h99, 1'b0, 1, 8'h00, 8'h00);
      access("t3 rd noalloc", 1'b1, 6'h11, 8'h00, 1'b0, 1, 8'h99, 8'h99);
      access("t3 rd again", 1'b1, 6'h11, 8'h00, 1'b1, 0, 8'h00, 8'h99);

      // 4: requests while busy are dropped
      ifc.cpu_req  = 1'b1;
      ifc.cpu_rwb  = 1'b1;
      ifc.cpu_addr = 6'h05;
      @(negedge clk);
      exp_miss_cnt = exp_miss_cnt + 8'd1;
      check("t4 mem_req", 32'(ifc.mem_req), 32'd1);
      ifc.cpu_addr = 6'h2A;
      @(negedge clk);
      check("t4 ignored rd ready", 32'(ifc.cpu_ready), 32'd0);
      check("t4 ignored rd addr", 32'(ifc.mem_addr), 32'h05);
      ifc.cpu_rwb   = 1'b0;
      ifc.cpu_addr  = 6'h11;
      ifc.cpu_wdata = 8'h55;
      @(negedge clk);
      check("t4 ignored wr rwb", 32'(ifc.mem_rwb), 32'd1);
      check("t4 ignored wr wdata", 32'(ifc.mem_wdata), 32'h00);
      check_counters("t4 busy");
      ifc.cpu_req   = 1'b0;
      ifc.mem_ack   = 1'b1;
      ifc.mem_rdata = 8'h44;
      @(negedge clk);
      ifc.mem_ack   = 1'b0;
      ifc.mem_rdata = 8'hEE;
      check("t4 ready", 32'(ifc.cpu_ready), 32'd1);
      check("t4 rdata", 32'(ifc.cpu_rdata), 32'h44);
      @(negedge clk);
      check("t4 no extra mem_req", 32'(ifc.mem_req), 32'd0);
      check("t4 no extra ready", 32'(ifc.cpu_ready), 32'd0);
      check_counters("t4 end");
      $display("access t4 RD addr=0x05 with two dropped requests");

      // mem_ack while idle has no effect
      ifc.mem_ack = 1'b1;
      @(negedge clk);
      ifc.mem_ack = 1'b0;
      check("idle ack ready", 32'(ifc.cpu_ready), 32'd0);
      check("idle ack busy", 32'(ifc.busy), 32'd0);

      // 5: reset aborts an outstanding read miss
      ifc.cpu_req  = 1'b1;
      ifc.cpu_rwb  = 1'b1;
      ifc.cpu_addr = 6'h06;
      @(negedge clk);
      ifc.cpu_req = 1'b0;
      check("t5 mem_req before", 32'(ifc.mem_req), 32'd1);
      start = 1'b1;
      @(negedge clk);
      start         = 1'b0;
      exp_hit_cnt   = 8'd0;
      exp_miss_cnt  = 8'd0;
      check("t5 mem_req dropped", 32'(ifc.mem_req), 32'd0);
      check("t5 no ready", 32'(ifc.cpu_ready), 32'd0);
      check("t5 busy", 32'(ifc.busy), 32'd0);
      check_counters("t5 rst");
      ifc.mem_ack   = 1'b1;
      ifc.mem_rdata = 8'h66;
      @(negedge clk);
      ifc.mem_ack   = 1'b0;
      ifc.mem_rdata = 8'hEE;
      check("t5 late ack ignored", 32'(ifc.cpu_ready), 32'd0);
      $display("access t5 RD addr=0x06 aborted by reset");
      access("t5 post-rst", 1'b1, 6'h2A, 8'h00, 1'b0, 1, 8'h5C, 8'h5C);
      access("t5 aborted line", 1'b1, 6'h06, 8'h00, 1'b0, 1, 8'h66, 8'h66);

      // 6: fill all 8 lines, then back-to-back hits and counter saturation
      do_reset();
      for (int i = 0; i < 8; i++)
         access($sformatf("t6 fill%0d", i), 1'b1, 6'(i), 8'h00, 1'b0, 1, 8'(8'hA0 + i),
                8'(8'hA0 + i));
      ifc.cpu_req = 1'b1;
      ifc.cpu_rwb = 1'b1;
      for (int i = 0; i < 8; i++) begin
         ifc.cpu_addr = 6'(i);
         @(negedge clk);
         check($sformatf("t6 b2b ready%0d", i), 32'(ifc.cpu_ready), 32'd1);
         check($sformatf("t6 b2b rdata%0d", i), 32'(ifc.cpu_rdata), 32'(8'hA0 + i));
         check($sformatf("t6 b2b busy%0d", i), 32'(ifc.busy), 32'd0);
         $display("access t6 b2b RD addr=0x%02h rdata=0x%02h", i, ifc.cpu_rdata);
      end
      check("t6 hit_cnt 8", 32'(ifc.hit_cnt), 32'd8);
      for (int i = 0; i < 300; i++) begin
         ifc.cpu_addr = 6'(i % 8);
         @(negedge clk);
      end
      ifc.cpu_req = 1'b0;
      check("t6 sat ready", 32'(ifc.cpu_ready), 32'd1);
      check("t6 hit_cnt sat", 32'(ifc.hit_cnt), 32'd255);
      check("t6 miss_cnt", 32'(ifc.miss_cnt), 32'd8);
      $display("access t6 300 back-to-back hits hit_cnt=%0d", ifc.hit_cnt);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
